icache_refill_axi: RTL

Responder end of the `InstReq`/`InstResp` handshake pair. It accepts one I-cache line-miss request (`pc`) at a time, issues a single 4-beat INCR AXI read burst for the 16-byte-aligned line, and assembles the beats into a 128-bit `cacheLine`. It returns the line to the I-cache. It sits between the ICache and the top-level AXI read channels (AR/R), and is the `axi`-modport owner of both instruction interfaces.

---
 rtl/icache_refill_axi_pkg.sv | 8 +
 rtl/icache_refill_axi.sv | 91 +++++++++
 2 files changed

// File: rtl/icache_refill_axi_pkg.sv
// icache_refill_axi_pkg: shared types and AXI constants for the I-cache line refill engine.
package icache_refill_axi_pkg;
    typedef enum logic [1:0] {REFILL_IDLE, REFILL_ADDR, REFILL_DATA, REFILL_RESP} refill_state_e;
    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
    localparam int         ICACHE_LINE_BEATS = 4;
    localparam logic [3:0] AXI_LINE_LEN      = 4'(ICACHE_LINE_BEATS - 1);
endpackage

// File: rtl/icache_refill_axi.sv
// icache_refill_axi: fetches one 16-byte I-cache line per miss with a single 4-beat INCR AXI read burst.
module icache_refill_axi
    import icache_refill_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inst_req_valid,
    input  logic [31:0]  inst_req_pc,
    output logic         inst_req_ready,
    input  logic         inst_resp_ready,
    output logic         inst_resp_valid,
    output logic [127:0] inst_resp_cache_line,
    output logic         axi_ar_valid,
    output logic [3:0]   axi_ar_id,
    output logic [31:0]  axi_ar_address,
    output logic [3:0]   axi_ar_length,
    output logic [2:0]   axi_ar_size,
    output logic [1:0]   axi_ar_burst,
    output logic         axi_ar_lock,
    output logic [3:0]   axi_ar_cache,
    output logic [2:0]   axi_ar_protect,
    input  logic         axi_ar_ready,
    input  logic         axi_r_valid,
    input  logic [3:0]   axi_r_id,
    input  logic [31:0]  axi_r_data,
    input  logic [1:0]   axi_r_respond,
    input  logic         axi_r_last,
    output logic         axi_r_ready
);
    refill_state_e   state_q, state_d;
    logic [31:0]     line_addr_q, line_addr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0][31:0] line_q, line_d;
    logic            unused_ok;

    // Error responses are not reported and the low pc bits are implied by line alignment.
    assign unused_ok = ^{axi_r_respond, inst_req_pc[3:0]};

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        case (state_q)
            REFILL_IDLE: if (inst_req_valid) begin
                line_addr_d = {inst_req_pc[31:4], 4'b0};
                cnt_d       = 2'd0;
                state_d     = REFILL_ADDR;
            end
            REFILL_ADDR: if (axi_ar_ready) state_d = REFILL_DATA;
            // Beats tagged with another id are swallowed without touching the line.
            REFILL_DATA: if (axi_r_valid && axi_r_id == AXI_ID) begin
                line_d[cnt_q] = axi_r_data;
                cnt_d         = cnt_q + 2'd1;
                if (axi_r_last) state_d = REFILL_RESP;
            end
            REFILL_RESP: if (inst_resp_ready) state_d = REFILL_IDLE;
            default: state_d = REFILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REFILL_IDLE;
            line_addr_q <= 32'b0;
            cnt_q       <= 2'd0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
        end
    end

    assign inst_req_ready       = state_q == REFILL_IDLE;
    assign axi_ar_valid         = state_q == REFILL_ADDR;
    assign axi_r_ready          = state_q == REFILL_DATA;
    assign inst_resp_valid      = state_q == REFILL_RESP;
    assign inst_resp_cache_line = line_q;
    assign axi_ar_address       = line_addr_q;
    assign axi_ar_id            = AXI_ID;
    assign axi_ar_length        = AXI_LINE_LEN;
    assign axi_ar_size          = AXI_SIZE_4B;
    assign axi_ar_burst         = AXI_BURST_INCR;
    assign axi_ar_lock          = 1'b0;
    assign axi_ar_cache         = 4'd0;
    assign axi_ar_protect       = 3'd0;
endmodule
